// File: rtl/parking_ctrl_pkg.sv
// Shared types and constants for the parking gate controller.
package parking_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PIN  = 3'd1,
    GATE_OPEN = 3'd2,
    CLOSING   = 3'd3,
    LOCKOUT   = 3'd4,
    BLOCK     = 3'd5
  } gate_state_e;

  localparam logic [15:0] DEFAULT_PIN       = 16'h5990;
  localparam logic [15:0] DEFAULT_ADMIN_PIN = 16'hA5A5;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/parking_pin_checker.sv
// PIN evaluation: code_ack edge detect, PIN compare, failed-attempt counter and entry timeout.
module parking_pin_checker
  import parking_ctrl_pkg::*;
#(
  parameter int                PIN_W        = 16,
  parameter logic [PIN_W-1:0]  PIN_VALUE    = PIN_W'(DEFAULT_PIN),
  parameter int                MAX_ATTEMPTS = 3,
  parameter int                TIMEOUT_CYC  = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [PIN_W-1:0]                       code,
  input  logic                                   code_ack,
  input  logic                                   eval_en,
  input  logic                                   clr_att,
  output logic                                   ack_edge,
  output logic                                   match,
  output logic                                   strike,
  output logic                                   lockout_hit,
  output logic [clog2_min1(MAX_ATTEMPTS+1)-1:0]  attempts
);

  localparam int                ATT_W    = clog2_min1(MAX_ATTEMPTS + 1);
  localparam int                TMR_W    = clog2_min1(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ATT_W-1:0]  ATT_MAX  = ATT_W'(MAX_ATTEMPTS);
  localparam logic [ATT_W-1:0]  ATT_LAST = ATT_W'(MAX_ATTEMPTS - 1);

  logic             code_ack_q, code_ack_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [ATT_W-1:0] attempts_q, attempts_d;
  logic             timeout;

  always_comb begin
    code_ack_d  = code_ack;
    ack_edge    = code_ack & ~code_ack_q;
    match       = (code == PIN_VALUE);
    // A timeout only fires on a cycle with no fresh ack; a coincident ack is the single strike.
    timeout     = (TIMEOUT_CYC != 0) && (timer_q == TMR_LAST) && !ack_edge;
    strike      = eval_en && ((ack_edge && !match) || timeout);
    lockout_hit = strike && (attempts_q == ATT_LAST);

    timer_d = '0;
    if (eval_en && !strike && !ack_edge && (TIMEOUT_CYC != 0))
      timer_d = timer_q + TMR_W'(1);

    attempts_d = attempts_q;
    if (clr_att)
      attempts_d = '0;
    else if (strike && (attempts_q != ATT_MAX))
      attempts_d = attempts_q + ATT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_ack_q <= 1'b0;
      timer_q    <= '0;
      attempts_q <= '0;
    end else begin
      code_ack_q <= code_ack_d;
      timer_q    <= timer_d;
      attempts_q <= attempts_d;
    end
  end

  assign attempts = attempts_q;

endmodule

// File: rtl/parking_gate_ctrl_param.sv
// Single-lane parking gate controller FSM with registered outputs.
// Optional ADMIN_PIN_EN macro adds an ADMIN_PIN that clears LOCKOUT/BLOCK back to IDLE.
module parking_gate_ctrl_param
  import parking_ctrl_pkg::*;
#(
  parameter int                PIN_W        = 16,
  parameter logic [PIN_W-1:0]  PIN_VALUE    = PIN_W'(DEFAULT_PIN),
  parameter int                MAX_ATTEMPTS = 3,
  parameter int                TIMEOUT_CYC  = 64
`ifdef ADMIN_PIN_EN
  , parameter logic [PIN_W-1:0] ADMIN_PIN   = PIN_W'(DEFAULT_ADMIN_PIN)
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   vehicle_arrival,
  input  logic                                   vehicle_left,
  input  logic [PIN_W-1:0]                       code,
  input  logic                                   code_ack,
  input  logic                                   gate_ack,
  output logic                                   gate_open,
  output logic                                   wrong_pin_alarm,
  output logic                                   block_alarm,
  output logic [clog2_min1(MAX_ATTEMPTS+1)-1:0]  attempts,
  output logic [2:0]                             state_o
);

  gate_state_e state_q, state_d;
  logic        gate_open_q, gate_open_d;
  logic        wrong_pin_alarm_q, wrong_pin_alarm_d;
  logic        block_alarm_q, block_alarm_d;
  logic        ack_edge, match, strike, lockout_hit;
  logic        eval_en, clr_att, admin_hit;

`ifdef ADMIN_PIN_EN
  assign admin_hit = ack_edge && (code == ADMIN_PIN);
`else
  assign admin_hit = 1'b0;
`endif

  // An exit sensor in WAIT_PIN aborts the entry and suppresses any same-cycle evaluation.
  assign eval_en = (state_q == WAIT_PIN) && !vehicle_left;

  parking_pin_checker #(
    .PIN_W        (PIN_W),
    .PIN_VALUE    (PIN_VALUE),
    .MAX_ATTEMPTS (MAX_ATTEMPTS),
    .TIMEOUT_CYC  (TIMEOUT_CYC)
  ) u_pin_checker (
    .clk          (clk),
    .rst          (rst),
    .code         (code),
    .code_ack     (code_ack),
    .eval_en      (eval_en),
    .clr_att      (clr_att),
    .ack_edge     (ack_edge),
    .match        (match),
    .strike       (strike),
    .lockout_hit  (lockout_hit),
    .attempts     (attempts)
  );

  always_comb begin
    state_d = state_q;
    clr_att = 1'b0;
    case (state_q)
      IDLE:      if (vehicle_arrival) state_d = WAIT_PIN;
      WAIT_PIN: begin
        if (vehicle_left) begin
          state_d = IDLE;
          clr_att = 1'b1;
        end else if (ack_edge && match) begin
          state_d = GATE_OPEN;
          clr_att = 1'b1;
        end else if (strike) begin
          state_d = lockout_hit ? LOCKOUT : WAIT_PIN;
        end
      end
      GATE_OPEN: begin
        if (vehicle_arrival && vehicle_left) state_d = BLOCK;
        else if (vehicle_left)               state_d = CLOSING;
      end
      CLOSING: begin
        if (gate_ack)                             state_d = IDLE;
        else if (vehicle_arrival && vehicle_left) state_d = BLOCK;
      end
      LOCKOUT: begin
        if (ack_edge && match) begin
          state_d = GATE_OPEN;
          clr_att = 1'b1;
        end else if (admin_hit) begin
          state_d = IDLE;
          clr_att = 1'b1;
        end
      end
      BLOCK: begin
        if (admin_hit) begin
          state_d = IDLE;
          clr_att = 1'b1;
        end
      end
      default:   state_d = IDLE;
    endcase

    gate_open_d       = (state_d == GATE_OPEN);
    wrong_pin_alarm_d = (state_d == LOCKOUT);
    block_alarm_d     = (state_d == BLOCK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= IDLE;
      gate_open_q       <= 1'b0;
      wrong_pin_alarm_q <= 1'b0;
      block_alarm_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      gate_open_q       <= gate_open_d;
      wrong_pin_alarm_q <= wrong_pin_alarm_d;
      block_alarm_q     <= block_alarm_d;
    end
  end

  assign gate_open       = gate_open_q;
  assign wrong_pin_alarm = wrong_pin_alarm_q;
  assign block_alarm     = block_alarm_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_parking_gate_ctrl_param.sv
// Directed and randomized bench for parking_gate_ctrl_param against a behavioural lane model.
module tb_parking_gate_ctrl_param;

  localparam logic [15:0] PIN   = 16'h5990;
  localparam logic [15:0] ADMIN = 16'hA5A5;
  localparam int          MAXA  = 3;
  localparam int          TO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arr = 1'b0, left = 1'b0, ack = 1'b0, gack = 1'b0;
  logic [15:0] code = 16'h0;

  logic        gate_open, wpa, blk;
  logic [1:0]  att;
  logic [2:0]  st;
  logic        gate_open1, wpa1, blk1;
  logic [0:0]  att1;
  logic [2:0]  st1;

  int total = 0;
  int bad   = 0;

  // Behavioural model: lane phase 0..5 (idle, waiting, open, closing, lockout, blocked)
  int   m_st, m_att, m_wait;
  logic m_prev;

  always #5 clk = ~clk;

  parking_gate_ctrl_param #(.MAX_ATTEMPTS(MAXA), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .vehicle_arrival(arr), .vehicle_left(left), .code(code),
    .code_ack(ack), .gate_ack(gack), .gate_open(gate_open), .wrong_pin_alarm(wpa),
    .block_alarm(blk), .attempts(att), .state_o(st));

  parking_gate_ctrl_param #(.MAX_ATTEMPTS(1), .TIMEOUT_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .vehicle_arrival(arr), .vehicle_left(left), .code(code),
    .code_ack(ack), .gate_ack(gack), .gate_open(gate_open1), .wrong_pin_alarm(wpa1),
    .block_alarm(blk1), .attempts(att1), .state_o(st1));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_att = 0; m_wait = 0; m_prev = 1'b0;
  endtask

  task automatic model_step(input logic a, input logic l, input logic [15:0] c,
                            input logic k, input logic g);
    logic fresh;
    fresh  = k && !m_prev;
    m_prev = k;
    case (m_st)
      0: if (a) begin m_st = 1; m_wait = 0; end
      1: begin
        if (l) begin
          m_st = 0; m_att = 0;
        end else if (fresh && c == PIN) begin
          m_st = 2; m_att = 0;
        end else begin
          m_wait++;
          if (fresh || m_wait == TO) begin
            m_att++;
            m_wait = 0;
            if (m_att >= MAXA) m_st = 4;
          end
        end
      end
      2: if (a && l) m_st = 5; else if (l) m_st = 3;
      3: if (g) m_st = 0; else if (a && l) m_st = 5;
      4: begin
        if (fresh && c == PIN) begin
          m_st = 2; m_att = 0;
        end
`ifdef ADMIN_PIN_EN
        else if (fresh && c == ADMIN) begin
          m_st = 0; m_att = 0;
        end
`endif
      end
      5: begin
`ifdef ADMIN_PIN_EN
        if (fresh && c == ADMIN) begin
          m_st = 0; m_att = 0;
        end
`endif
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic check_model();
    chk("state",     16'(st),        16'(m_st));
    chk("gate_open", 16'(gate_open), 16'(m_st == 2));
    chk("wpa",       16'(wpa),       16'(m_st == 4));
    chk("blk",       16'(blk),       16'(m_st == 5));
    chk("attempts",  16'(att),       16'(m_att));
  endtask

  task automatic cyc(input logic a, input logic l, input logic [15:0] c,
                     input logic k, input logic g);
    arr = a; left = l; code = c; ack = k; gack = g;
    model_step(a, l, c, k, g);
    @(posedge clk); #1;
    check_model();
  endtask

  // Reset lands between clock edges, so outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("async_state", 16'(st),        16'd0);
    chk("async_gate",  16'(gate_open), 16'd0);
    chk("async_wpa",   16'(wpa),       16'd0);
    chk("async_blk",   16'(blk),       16'd0);
    chk("async_att",   16'(att),       16'd0);
    arr = 0; left = 0; ack = 0; gack = 0; code = 16'h0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    chk("rst_state", 16'(st),        16'd0);
    chk("rst_gate",  16'(gate_open), 16'd0);
    chk("rst_att",   16'(att),       16'd0);
    rst = 1'b1;

    // 1: admit and close
    cyc(1, 0, 16'h0, 0, 0);
    cyc(1, 0, PIN, 1, 0);
    chk("t1_open", 16'(gate_open), 16'd1);
    cyc(0, 0, PIN, 0, 0);
    cyc(0, 1, 16'h0, 0, 0);
    chk("t1_closing", 16'(st), 16'd3);
    cyc(0, 0, 16'h0, 0, 1);
    chk("t1_idle", 16'(st), 16'd0);

    // 2: two wrong PINs then abort; single-attempt instance locks at once
    do_reset();
    cyc(1, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h1234, 1, 0);
    chk("t2_att1", 16'(att), 16'd1);
    chk("t2_max1_state", 16'(st1), 16'd4);
    chk("t2_max1_wpa", 16'(wpa1), 16'd1);
    chk("t2_max1_att", 16'(att1), 16'd1);
    cyc(0, 0, 16'h1234, 0, 0);
    cyc(0, 0, 16'h3145, 1, 0);
    chk("t2_att2", 16'(att), 16'd2);
    cyc(0, 1, 16'h0, 0, 0);
    chk("t2_att0", 16'(att), 16'd0);
    chk("t2_idle", 16'(st), 16'd0);
    chk("t2_noalarm", 16'(wpa), 16'd0);

    // 3: lockout, saturation, recovery by correct PIN
    do_reset();
    cyc(1, 0, 16'h0, 0, 0);
    cyc(0, 0, 16'h1234, 1, 0); cyc(0, 0, 16'h1234, 0, 0);
    cyc(0, 0, 16'h3145, 1, 0); cyc(0, 0, 16'h3145, 0, 0);
    cyc(0, 0, 16'h4321, 1, 0);
    chk("t3_alarm", 16'(wpa), 16'd1);
    chk("t3_att3", 16'(att), 16'd3);
    cyc(0, 0, 16'h4321, 0, 0);
    cyc(1, 1, 16'h5555, 1, 0);
    chk("t3_keep_alarm", 16'(wpa), 16'd1);
    chk("t3_sat", 16'(att), 16'd3);
    cyc(0, 0, 16'h5555, 0, 0);
    cyc(0, 0, PIN, 1, 0);
    chk("t3_open", 16'(gate_open), 16'd1);
    chk("t3_alarm_clr", 16'(wpa), 16'd0);
    chk("t3_att_clr", 16'(att), 16'd0);

    // 4: tailgating block, then reset
    do_reset();
    cyc(1, 0, 16'h0, 0, 0);
    cyc(0, 0, PIN, 1, 0);
    cyc(1, 1, PIN, 0, 0);
    chk("t4_block", 16'(blk), 16'd1);
    chk("t4_gate0", 16'(gate_open), 16'd0);
    cyc(0, 0, PIN, 1, 0);
    chk("t4_stay", 16'(st), 16'd5);
    do_reset();

    // 5: timeout strikes, then a held ack counts once
    cyc(1, 0, 16'h0, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      cyc(0, 0, 16'h0, 0, 0);
      if (i == 8)  chk("t5_to1", 16'(att), 16'd1);
      if (i == 16) chk("t5_to2", 16'(att), 16'd2);
    end
    chk("t5_lock", 16'(st), 16'd4);
    do_reset();
    cyc(1, 0, 16'h0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 16'h1234, 1, 0);
    chk("t5_held", 16'(att), 16'd1);

    // 6: admin PIN in BLOCK
    do_reset();
    cyc(1, 0, 16'h0, 0, 0);
    cyc(0, 0, PIN, 1, 0);
    cyc(1, 1, 16'h0, 0, 0);
    cyc(0, 0, ADMIN, 1, 0);
`ifdef ADMIN_PIN_EN
    chk("t6_admin_idle", 16'(st), 16'd0);
    chk("t6_admin_blk", 16'(blk), 16'd0);
`else
    chk("t6_no_admin", 16'(st), 16'd5);
    chk("t6_no_admin_blk", 16'(blk), 16'd1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic        a, l, k, g;
      logic [15:0] c;
      int          sel;
      a   = ($urandom_range(0, 3) == 0);
      l   = ($urandom_range(0, 5) == 0);
      k   = ($urandom_range(0, 2) == 0);
      g   = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      c   = (sel == 0) ? PIN : (sel == 1) ? ADMIN : 16'($urandom);
      if ((m_st == 5 && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0)
        do_reset();
      cyc(a, l, c, k, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
